decode_inst_queue: RTL and testbench

DECODE_INST_QUEUE -- requirements
Module: decode_inst_queue

---
 rtl/decode_inst_queue.sv | 91 +++++++++
 tb/tb_decode_inst_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/decode_inst_queue.sv
// Instruction queue between fetch and decode: circular buffer with optional
// same-cycle bypass when empty, flush-to-empty and a held head payload.
module decode_inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fe_to_de_valid,
  input  logic [31:0]      Inst_IF,
  input  logic [31:0]      PC_IF,
  input  logic             PC_AdEL_IF,
  input  logic             DSI_IF,
  output logic             queue_allowin,
  output logic             q_to_de_valid,
  input  logic             decode_allowin,
  output logic [31:0]      Inst_Q,
  output logic [31:0]      PC_Q,
  output logic             PC_AdEL_Q,
  output logic             DSI_Q,
  output logic [31:0]      PC_add_4_Q,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 66;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic [ENT_W-1:0] last_q;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] out_ent;
  logic             empty;
  logic             head_valid;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_en;

  // Head selection, handshake and pointer enables
  always_comb begin
    in_ent        = {(PC_AdEL_IF ? 32'd0 : Inst_IF), PC_IF, PC_AdEL_IF, DSI_IF};
    empty         = (cnt == '0);
    head          = empty ? in_ent : mem[rptr];
    head_valid    = !rst && !flush &&
                    (!empty || ((BYPASS != 0) && fe_to_de_valid));
    queue_allowin = rst || (cnt < CNT_W'(DEPTH)) || decode_allowin;
    push          = fe_to_de_valid && queue_allowin && !flush && !rst;
    pop           = head_valid && decode_allowin;
    // A bypassed entry consumed while empty is never written
    wr_en         = push && !(empty && pop);
    rd_en         = pop && !empty;
    out_ent       = head_valid ? head : last_q;
  end

  assign q_to_de_valid = head_valid;
  assign count         = rst ? '0 : cnt;
  assign {Inst_Q, PC_Q, PC_AdEL_Q, DSI_Q} = out_ent;
  assign PC_add_4_Q    = PC_Q + 32'd4;

  // Occupancy, pointers and last-presented head
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wptr   <= '0;
      rptr   <= '0;
      last_q <= '0;
    end else if (flush) begin
      cnt    <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      if (rd_en) rptr <= rptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (head_valid) last_q <= head;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= in_ent;
  end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Bench for decode_inst_queue: BYPASS=0 and BYPASS=1 instances share stimulus,
// each checked every cycle against its own queue-based reference model.
module tb_decode_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
    logic        dsi;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_to_de_valid;
  logic [31:0] Inst_IF;
  logic [31:0] PC_IF;
  logic        PC_AdEL_IF;
  logic        DSI_IF;
  logic        decode_allowin;
  logic        flush;
  logic        chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [bypass=%0d] t=%0t: got %h want %h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0]      inst_q, pc_q, pc4_q;
    logic             adel_q, dsi_q, allow, qv;
    logic [CNT_W-1:0] cnt;
    ent_t             mq[$];
    ent_t             last;

    decode_inst_queue #(.DEPTH(DEPTH), .BYPASS(g)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .fe_to_de_valid (fe_to_de_valid),
      .Inst_IF        (Inst_IF),
      .PC_IF          (PC_IF),
      .PC_AdEL_IF     (PC_AdEL_IF),
      .DSI_IF         (DSI_IF),
      .queue_allowin  (allow),
      .q_to_de_valid  (qv),
      .decode_allowin (decode_allowin),
      .Inst_Q         (inst_q),
      .PC_Q           (pc_q),
      .PC_AdEL_Q      (adel_q),
      .DSI_Q          (dsi_q),
      .PC_add_4_Q     (pc4_q),
      .flush          (flush),
      .count          (cnt)
    );

    // Monitor: compare mid-cycle, then advance the model to the next edge
    always @(negedge clk) begin
      if (chk_en) begin
        ent_t in_e, head_e;
        logic exp_v, exp_allow, push, pop;
        in_e   = '{inst: (PC_AdEL_IF ? 32'd0 : Inst_IF), pc: PC_IF,
                   adel: PC_AdEL_IF, dsi: DSI_IF};
        head_e = (mq.size() > 0) ? mq[0] : in_e;
        exp_v  = !rst && !flush && ((mq.size() > 0) || (g == 1 && fe_to_de_valid));
        exp_allow = rst || (mq.size() < DEPTH) || decode_allowin;
        chk("count", g, 32'(cnt), rst ? 32'd0 : 32'(mq.size()));
        chk("queue_allowin", g, 32'(allow), 32'(exp_allow));
        chk("q_to_de_valid", g, 32'(qv), 32'(exp_v));
        if (exp_v) begin
          chk("Inst_Q", g, inst_q, head_e.inst);
          chk("PC_Q", g, pc_q, head_e.pc);
          chk("PC_add_4_Q", g, pc4_q, head_e.pc + 32'd4);
          chk("tags", g, {30'd0, adel_q, dsi_q}, {30'd0, head_e.adel, head_e.dsi});
        end else if (!rst) begin
          chk("hold_Inst_Q", g, inst_q, last.inst);
          chk("hold_PC_Q", g, pc_q, last.pc);
          chk("hold_tags", g, {30'd0, adel_q, dsi_q}, {30'd0, last.adel, last.dsi});
        end
        if (rst) begin
          mq.delete();
          last = '0;
        end else if (flush) begin
          mq.delete();
        end else begin
          if (exp_v) last = head_e;
          push = fe_to_de_valid && exp_allow;
          pop  = exp_v && decode_allowin;
          if (push) mq.push_back(in_e);
          if (pop) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic fe, input logic da, input logic fl, input logic r,
                     input logic [31:0] inst, input logic [31:0] pc,
                     input logic adel, input logic dsi);
    fe_to_de_valid = fe;
    decode_allowin = da;
    flush          = fl;
    rst            = r;
    Inst_IF        = inst;
    PC_IF          = pc;
    PC_AdEL_IF     = adel;
    DSI_IF         = dsi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 1, 32'd0, 32'd0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 1, 32'd0, 32'd0, 0, 0);
    // Fill four, offer a fifth while blocked, then drain in order
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 0, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Full queue streaming: push and pop every cycle
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 32'h2000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 32'h3000 + 32'(i), 32'h300 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Empty queue bypass
    cyc(1, 1, 0, 0, 32'h24020001, 32'h400, 0, 0);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Three held, then flush with push and pop
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'h5000 + 32'(i), 32'h500 + 32'(4 * i), 0, 0);
    cyc(1, 1, 1, 0, 32'hDEAD0000, 32'h5FC, 0, 0);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Tagged entries
    cyc(1, 0, 0, 0, 32'h12345678, 32'h600, 1, 1);
    cyc(1, 0, 0, 0, 32'h87654321, 32'h604, 0, 1);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Reset with two held, then resume
    cyc(1, 0, 0, 0, 32'h7000, 32'h700, 0, 0);
    cyc(1, 0, 0, 0, 32'h7001, 32'h704, 0, 0);
    cyc(1, 1, 0, 1, 32'h7002, 32'h708, 0, 0);
    cyc(1, 0, 0, 0, 32'h8000, 32'h800, 0, 0);
    cyc(1, 0, 0, 0, 32'h8001, 32'h804, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 200) % 3;
      cyc(($urandom % 4) != 0,
          phase == 0 ? ($urandom % 4) == 0 : phase == 1 ? ($urandom % 2) == 0 : ($urandom % 4) != 0,
          ($urandom % 25) == 0, ($urandom % 150) == 0,
          $urandom, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
          ($urandom % 8) == 0, ($urandom % 4) == 0);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
